// File: rtl/atm_pkg.sv
// Shared types and default parameter values for the balance ledger.
package atm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DEF_BAL_W        = 8;
    localparam int DEF_INIT_BAL     = 100;
    localparam int DEF_MAX_BAL      = 250;
    localparam int DEF_WD_LIMIT     = 5;
    localparam int DEF_LOCK_REJECTS = 3;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/balance_ledger_if.sv
// Request/status bundle between the deposit/withdraw stages and the ledger.
interface balance_ledger_if #(
    parameter int BAL_W = 8
);
    logic             count_up;
    logic             count_down;
    logic             session_start;
    logic             session_end;
    logic [BAL_W-1:0] balance;
    logic [3:0]       wd_count;
    logic             denied;
    logic             locked;
    logic             active;

    modport master (
        output count_up, count_down, session_start, session_end,
        input  balance, wd_count, denied, locked, active
    );

    modport slave (
        input  count_up, count_down, session_start, session_end,
        output balance, wd_count, denied, locked, active
    );
endinterface

// File: rtl/sat_updown_counter.sv
// Registered up/down counter that saturates at MIN and MAX instead of wrapping.
module sat_updown_counter #(
    parameter int W    = 8,
    parameter int MIN  = 0,
    parameter int MAX  = 250,
    parameter int INIT = 100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_min,
    output logic         at_max
);
    localparam logic [W-1:0] MIN_V  = W'(MIN);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);
    localparam logic [W-1:0] ONE_V  = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= INIT_V;
        end else if (inc && !dec && (r_count < MAX_V)) begin
            r_count <= r_count + ONE_V;
        end else if (dec && !inc && (r_count > MIN_V)) begin
            r_count <= r_count - ONE_V;
        end
    end

    assign count  = r_count;
    assign at_min = (r_count <= MIN_V);
    assign at_max = (r_count >= MAX_V);

endmodule

// File: rtl/balance_ledger.sv
// Session-based balance ledger: deposits/withdrawals with per-session limits and lockout.
module balance_ledger
    import atm_pkg::*;
#(
    parameter int BAL_W        = DEF_BAL_W,
    parameter int INIT_BAL     = DEF_INIT_BAL,
    parameter int MAX_BAL      = DEF_MAX_BAL,
    parameter int WD_LIMIT     = DEF_WD_LIMIT,
    parameter int LOCK_REJECTS = DEF_LOCK_REJECTS
) (
    input  logic               clk,
    input  logic               reset,
    balance_ledger_if.slave    bus
);
    localparam int             REJ_W    = cnt_width(LOCK_REJECTS);
    localparam logic [3:0]     WD_LIM   = 4'(WD_LIMIT);
    localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(LOCK_REJECTS - 1);

    state_t             r_state;
    logic [3:0]         r_wd;
    logic [REJ_W-1:0]   r_rej;
    logic               r_denied;
    logic               r_locked;
    logic               r_active;

    logic [BAL_W-1:0]   w_balance;
    logic               w_at_min;
    logic               w_at_max;
    logic               w_live;
    logic               w_up_only;
    logic               w_dn_only;
    logic               w_dec_ok;

    // session_end pre-empts any same-cycle request, so requests are live only without it
    assign w_live    = (r_state == ST_ACTIVE) && !bus.session_end;
    assign w_up_only = bus.count_up && !bus.count_down;
    assign w_dn_only = bus.count_down && !bus.count_up;
    assign w_dec_ok  = !w_at_min && (r_wd < WD_LIM);

    sat_updown_counter #(
        .W    (BAL_W),
        .MIN  (0),
        .MAX  (MAX_BAL),
        .INIT (INIT_BAL)
    ) u_bal (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_live && w_up_only),
        .dec    (w_live && w_dn_only && w_dec_ok),
        .count  (w_balance),
        .at_min (w_at_min),
        .at_max (w_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wd     <= '0;
            r_rej    <= '0;
            r_denied <= 1'b0;
            r_locked <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_denied <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.session_start) begin
                        r_state  <= ST_ACTIVE;
                        r_wd     <= '0;
                        r_rej    <= '0;
                        r_active <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.session_end) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end else if (w_up_only) begin
                        if (w_at_max) r_denied <= 1'b1;
                    end else if (w_dn_only) begin
                        if (w_dec_ok) begin
                            r_wd <= r_wd + 4'd1;
                        end else begin
                            r_denied <= 1'b1;
                            r_rej    <= r_rej + 1'b1;
                            // lock on the same edge as the refusal that reaches the limit
                            if (r_rej >= REJ_LAST) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_active <= 1'b0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    r_locked <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.balance  = w_balance;
    assign bus.wd_count = r_wd;
    assign bus.denied   = r_denied;
    assign bus.locked   = r_locked;
    assign bus.active   = r_active;

endmodule

// File: tb/tb_balance_ledger.sv
// Randomized and directed bench for balance_ledger against a behavioural model.
module tb_balance_ledger;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    balance_ledger_if #(.BAL_W(8)) ia ();
    balance_ledger_if #(.BAL_W(8)) ib ();

    balance_ledger #(
        .BAL_W(8), .INIT_BAL(100), .MAX_BAL(250), .WD_LIMIT(5), .LOCK_REJECTS(3)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(ia)
    );

    balance_ledger #(
        .BAL_W(8), .INIT_BAL(0), .MAX_BAL(250), .WD_LIMIT(5), .LOCK_REJECTS(3)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(ib)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    // model state: index 0 -> u_dut, index 1 -> u_dut0
    int m_init [2] = '{100, 0};
    int m_bal  [2] = '{100, 0};
    int m_wd   [2] = '{0, 0};
    int m_rej  [2] = '{0, 0};
    bit m_act  [2] = '{0, 0};
    bit m_lck  [2] = '{0, 0};
    bit m_den  [2] = '{0, 0};

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_step(input int k, input bit rst, input bit up,
                                       input bit dn, input bit ss, input bit se);
        m_den[k] = 1'b0;
        if (rst) begin
            m_bal[k] = m_init[k];
            m_wd[k]  = 0;
            m_rej[k] = 0;
            m_act[k] = 1'b0;
            m_lck[k] = 1'b0;
        end else if (m_lck[k]) begin
            // locked: everything ignored
        end else if (!m_act[k]) begin
            if (ss) begin
                m_act[k] = 1'b1;
                m_wd[k]  = 0;
                m_rej[k] = 0;
            end
        end else if (se) begin
            m_act[k] = 1'b0;
        end else if (up && !dn) begin
            if (m_bal[k] < 250) m_bal[k] = m_bal[k] + 1;
            else m_den[k] = 1'b1;
        end else if (dn && !up) begin
            if (m_bal[k] > 0 && m_wd[k] < 5) begin
                m_bal[k] = m_bal[k] - 1;
                m_wd[k]  = m_wd[k] + 1;
            end else begin
                m_den[k] = 1'b1;
                m_rej[k] = m_rej[k] + 1;
                if (m_rej[k] >= 3) begin
                    m_lck[k] = 1'b1;
                    m_act[k] = 1'b0;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("a.balance",  int'(ia.balance),  m_bal[0]);
            chk("a.wd_count", int'(ia.wd_count), m_wd[0]);
            chk("a.denied",   int'(ia.denied),   int'(m_den[0]));
            chk("a.locked",   int'(ia.locked),   int'(m_lck[0]));
            chk("a.active",   int'(ia.active),   int'(m_act[0]));
            chk("b.balance",  int'(ib.balance),  m_bal[1]);
            chk("b.wd_count", int'(ib.wd_count), m_wd[1]);
            chk("b.denied",   int'(ib.denied),   int'(m_den[1]));
            chk("b.locked",   int'(ib.locked),   int'(m_lck[1]));
            chk("b.active",   int'(ib.active),   int'(m_act[1]));
        end
    end

    task automatic cycle(input bit rst, input bit up, input bit dn, input bit ss, input bit se);
        reset = rst;
        ia.count_up = up; ia.count_down = dn; ia.session_start = ss; ia.session_end = se;
        ib.count_up = up; ib.count_down = dn; ib.session_start = ss; ib.session_end = se;
        @(posedge clk);
        model_step(0, rst, up, dn, ss, se);
        model_step(1, rst, up, dn, ss, se);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        ia.count_up = 0; ia.count_down = 0; ia.session_start = 0; ia.session_end = 0;
        ib.count_up = 0; ib.count_down = 0; ib.session_start = 0; ib.session_end = 0;

        // reset state
        cycle(1, 1, 0, 1, 0);
        check_en = 1'b1;
        cycle(1, 0, 0, 0, 0);
        chk("rst.bal",    int'(ia.balance), 100);
        chk("rst.bal0",   int'(ib.balance), 0);
        chk("rst.wd",     int'(ia.wd_count), 0);
        chk("rst.active", int'(ia.active), 0);
        chk("rst.locked", int'(ia.locked), 0);

        // ignored requests in IDLE
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("idle.bal",    int'(ia.balance), 100);
        chk("idle.denied", int'(ia.denied), 0);

        // session with three withdrawals; INIT_BAL=0 instance locks
        cycle(0, 0, 0, 1, 0);
        chk("ss.active", int'(ia.active), 1);
        cycle(0, 0, 1, 0, 0);
        chk("wd1.bal", int'(ia.balance), 99);
        chk("wd1.den0", int'(ib.denied), 1);
        cycle(0, 0, 1, 0, 0);
        chk("wd2.bal", int'(ia.balance), 98);
        cycle(0, 0, 1, 0, 0);
        chk("wd3.bal", int'(ia.balance), 97);
        chk("wd3.wd",  int'(ia.wd_count), 3);
        chk("wd3.den", int'(ia.denied), 0);
        chk("lock0.locked", int'(ib.locked), 1);
        chk("lock0.bal",    int'(ib.balance), 0);
        chk("lock0.den",    int'(ib.denied), 1);

        // withdrawals 4..6: sixth hits the per-session limit
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("wd5.bal", int'(ia.balance), 95);
        cycle(0, 0, 1, 0, 0);
        chk("wd6.den", int'(ia.denied), 1);
        chk("wd6.bal", int'(ia.balance), 95);
        chk("wd6.wd",  int'(ia.wd_count), 5);

        // session_start on locked instance ignored
        cycle(0, 0, 0, 1, 0);
        chk("lock0.ss", int'(ib.locked), 1);
        chk("lock0.act", int'(ib.active), 0);

        // simultaneous up/down in ACTIVE
        cycle(0, 1, 1, 0, 0);
        chk("both.bal", int'(ia.balance), 95);
        chk("both.den", int'(ia.denied), 0);

        // session_end beats a same-cycle request; wd_count retained
        cycle(0, 1, 0, 0, 1);
        chk("se.bal",    int'(ia.balance), 95);
        chk("se.wd",     int'(ia.wd_count), 5);
        chk("se.active", int'(ia.active), 0);

        // fill to MAX_BAL, then one more deposit is refused
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 155; i++) cycle(0, 1, 0, 0, 0);
        chk("max.bal", int'(ia.balance), 250);
        cycle(0, 1, 0, 0, 0);
        chk("max.den",  int'(ia.denied), 1);
        chk("max.bal2", int'(ia.balance), 250);
        chk("max.lck",  int'(ia.locked), 0);

        // exhaust withdrawals, lock, then reset mid-lock
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0);
        chk("lockA.locked", int'(ia.locked), 1);
        chk("lockA.bal",    int'(ia.balance), 245);
        cycle(1, 1, 0, 1, 0);
        chk("rstL.bal",    int'(ia.balance), 100);
        chk("rstL.locked", int'(ia.locked), 0);
        chk("rstL.active", int'(ia.active), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 24) == 0);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/balance_ledger.md
BALANCE_LEDGER -- requirements
Module: balance_ledger

Interface
REQ-001 SHALL have parameter BAL_W, default 8, balance register width.
REQ-002 SHALL have parameter INIT_BAL, default 100, balance loaded at reset.
REQ-003 SHALL have parameter MAX_BAL, default 250, deposit ceiling (must be less than 2^BAL_W).
REQ-004 SHALL have parameter WD_LIMIT, default 5, withdrawals allowed per session.
REQ-005 SHALL have parameter LOCK_REJECTS, default 3, denied withdrawals per session before lockout.
REQ-006 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port count_up  input  1  deposit request; one-cycle pulse from the deposit stage.
REQ-009 SHALL have port count_down  input  1  withdraw request; one-cycle pulse from the withdraw stage.
REQ-010 SHALL have port session_start  input  1  card-inserted pulse.
REQ-011 SHALL have port session_end  input  1  card-ejected pulse.
REQ-012 SHALL have port balance  output  BAL_W  current balance, registered.
REQ-013 SHALL have port wd_count  output  4  withdrawals accepted in the current session.
REQ-014 SHALL have port denied  output  1  one-cycle pulse when a request is refused.
REQ-015 SHALL have port locked  output  1  high while in LOCKED.
REQ-016 SHALL have port active  output  1  high while in ACTIVE.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE, LOCKED; all outputs registered; request-to-output latency exactly 1 cycle.
REQ-018 IDLE: count_up/count_down ignored (no balance change, no denied); session_start -> ACTIVE, clears wd_count and reject counter.
REQ-019 ACTIVE, count_up alone: balance < MAX_BAL -> balance+1; else balance unchanged, denied=1 (no reject count).
REQ-020 ACTIVE, count_down alone: balance > 0 and wd_count < WD_LIMIT -> balance-1, wd_count+1; else denied=1, reject counter +1.
REQ-021 ACTIVE, count_up and count_down same cycle: net zero; balance, wd_count, reject counter unchanged, denied=0.
REQ-022 ACTIVE: reject counter reaching LOCK_REJECTS -> LOCKED on the same edge as the refusing denied pulse.
REQ-023 ACTIVE: session_end -> IDLE, wd_count retained until next session_start; session_end takes priority over a same-cycle count_up/count_down (request dropped, no denied).
REQ-024 ACTIVE: session_start while ACTIVE is ignored.
REQ-025 LOCKED: all inputs ignored, locked=1, denied=0; exit only by reset.
REQ-026 Balance SHALL never wrap: no decrement below 0, no increment above MAX_BAL.

Reset
REQ-027 On reset: state IDLE, balance=INIT_BAL, wd_count=0, reject counter=0, denied=0, locked=0, active=0.
REQ-028 Reset SHALL win over any same-cycle input, including mid-session and in LOCKED.

Structure
REQ-029 SHALL place the FSM state enum and default parameter values in shared package atm_pkg.
REQ-030 SHALL place the saturating up/down counter in sub-module sat_updown_counter (inc, dec, min, max, at_min, at_max).

Verification
REQ-031 Reset, session_start, 3 count_down pulses -> balance 100,99,98,97; wd_count 3; denied 0.
REQ-032 Session, 6 count_down pulses -> first 5 accepted (balance 95); 6th gives denied=1, balance stays 95.
REQ-033 INIT_BAL=0, session, 3 count_down pulses -> 3 denied pulses, balance 0, locked=1 after 3rd; further session_start ignored.
REQ-034 Balance at 250, count_up -> denied=1, balance 250, not locked.
REQ-035 count_up and count_down same cycle in ACTIVE -> balance unchanged, denied 0; same in IDLE -> no change.
REQ-036 Reset asserted while LOCKED mid-session -> next cycle balance=100, IDLE, locked=0.
